// File: rtl/parity_scan_controller.sv
// parity_scan_controller: scans a word two bits per cycle through an XNOR parity cell and checks it against a supplied parity bit
module parity_scan_controller #(
    parameter int WIDTH      = 8,
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [WIDTH-1:0]                 in_data,
    input  logic                             in_par,
    input  logic                             abort,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             out_parity,
    output logic                             out_err,
    output logic                             busy,
    output logic [$clog2(WIDTH/2+1)-1:0]     step
);
    localparam int SW = $clog2(WIDTH/2+1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] word;
    logic             par;
    logic             acc;
    logic [SW-1:0]    cnt;
    logic             load;
    logic             last;

    function automatic logic xnor3(input logic a, input logic b, input logic c);
        return ~(a ^ b ^ c);
    endfunction

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // next state and outputs; results are masked to zero outside DONE
    always_comb begin
        in_ready   = rst_n & ((state == IDLE) | ((state == DONE) & out_ready));
        load       = in_valid & in_ready;
        last       = cnt == SW'(WIDTH/2-1);
        busy       = state == SCAN;
        out_valid  = state == DONE;
        out_parity = out_valid & (acc ^ ODD_PARITY);
        out_err    = out_valid & (acc ^ ODD_PARITY ^ par);
        step       = busy ? cnt : '0;
        state_nx   = state == SCAN ? (abort ? IDLE : last ? DONE : SCAN) :
                     load ? SCAN :
                     ((state == DONE) & out_ready) ? IDLE : state;
    end

    // capture the word on accept, then shift one bit pair per SCAN cycle into the accumulator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word <= '0;
            par  <= 1'b0;
            acc  <= 1'b0;
            cnt  <= '0;
        end else if (load) begin
            word <= in_data;
            par  <= in_par;
            acc  <= 1'b0;
            cnt  <= '0;
        end else if (state == SCAN) begin
            acc  <= ~xnor3(acc, word[0], word[1]);
            word <= word >> 2;
            cnt  <= cnt + SW'(1);
        end
    end
endmodule

// File: tb/tb_parity_scan_controller.sv
// tb_parity_scan_controller: randomized and directed checks of the parity scan controller against a parity model
module tb_parity_scan_controller;
    localparam int W  = 8;
    localparam int H  = W/2;
    localparam int SW = $clog2(H+1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_par = 1'b0;
    logic          abort = 1'b0;
    logic          out_ready = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic          in_ready, out_valid, out_parity, out_err, busy;
    logic [SW-1:0] step;
    logic          in_ready1, out_valid1, out_parity1, out_err1, busy1;
    logic [SW-1:0] step1;
    int            vectors = 0;
    int            miscompares = 0;

    parity_scan_controller #(.WIDTH(W), .ODD_PARITY(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_par(in_par), .abort(abort), .out_valid(out_valid),
        .out_ready(out_ready), .out_parity(out_parity), .out_err(out_err),
        .busy(busy), .step(step)
    );

    parity_scan_controller #(.WIDTH(W), .ODD_PARITY(1'b1)) dut_odd (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .in_data(in_data), .in_par(in_par), .abort(abort), .out_valid(out_valid1),
        .out_ready(out_ready), .out_parity(out_parity1), .out_err(out_err1),
        .busy(busy1), .step(step1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic ref_par(input logic [W-1:0] d, input bit odd);
        return (^d) ^ odd;
    endfunction

    task automatic expect_idle(input string tag);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_parity"}, out_parity, 0);
        check({tag, "_out_err"}, out_err, 0);
        check({tag, "_step"}, step, 0);
        check({tag, "_in_ready_odd"}, in_ready1, 1);
        check({tag, "_busy_odd"}, busy1, 0);
    endtask

    task automatic check_result(input string tag, input logic [W-1:0] d, input logic p);
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_parity"}, out_parity, ref_par(d, 0));
        check({tag, "_err"}, out_err, ref_par(d, 0) ^ p);
        check({tag, "_valid_odd"}, out_valid1, 1);
        check({tag, "_parity_odd"}, out_parity1, ref_par(d, 1));
        check({tag, "_err_odd"}, out_err1, ref_par(d, 1) ^ p);
    endtask

    task automatic accept(input logic [W-1:0] d, input logic p);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_par   = p;
        check("accept_ready", in_ready, 1);
        @(posedge clk);
    endtask

    task automatic scan_word(input logic [W-1:0] d, input logic p, input int hold);
        accept(d, p);
        for (int i = 0; i < H; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            check("scan_busy", busy, 1);
            check("scan_step", step, i);
            check("scan_step_odd", step1, i);
            check("scan_no_valid", out_valid, 0);
            check("scan_not_ready", in_ready, 0);
        end
        @(negedge clk);
        check_result("done", d, p);
        check("done_not_ready", in_ready, 0);
        check("done_busy", busy, 0);
        check("done_step", step, 0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_result("hold", d, p);
            check("hold_not_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        #1;
        check("done_ready_comb", in_ready, 1);
        @(negedge clk);
        out_ready = 1'b0;
        expect_idle("after_done");
    endtask

    task automatic abort_at(input logic [W-1:0] d, input int k);
        accept(d, 1'b0);
        for (int i = 0; i <= k; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            check("abort_step", step, i);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        expect_idle("abort");
        for (int i = 0; i < H+2; i++) begin
            @(negedge clk);
            check("abort_no_valid", out_valid, 0);
        end
    endtask

    task automatic back_to_back();
        int cyc;
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = 8'hFF;
        in_par    = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_data = 8'h01;
        in_par  = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!out_valid && cyc < 20);
        check("b2b_interval1", cyc, H+1);
        check_result("b2b_first", 8'hFF, 1'b0);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                check("b2b_no_bubble", busy, 1);
                in_valid = 1'b0;
            end
        end while (!out_valid && cyc < 20);
        check("b2b_interval2", cyc, H+1);
        check_result("b2b_second", 8'h01, 1'b1);
        @(negedge clk);
        out_ready = 1'b0;
        expect_idle("b2b_end");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_parity", out_parity, 0);
        check("rst_err", out_err, 0);
        check("rst_busy", busy, 0);
        check("rst_step", step, 0);
        check("rst_in_ready", in_ready, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        expect_idle("post_reset");

        scan_word(8'hA5, 1'b0, 0);
        scan_word(8'h07, 1'b0, 0);
        scan_word(8'h3C, 1'b1, 10);
        back_to_back();
        abort_at(8'h3C, 2);
        abort_at(8'hC3, H-1);

        accept(8'h5B, 1'b1);
        repeat (H+1) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        check_result("abort_in_done_pre", 8'h5B, 1'b1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_result("abort_in_done", 8'h5B, 1'b1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        expect_idle("abort_in_done_end");

        accept(8'h5A, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", out_valid, 0);
        check("midrst_parity", out_parity, 0);
        check("midrst_err", out_err, 0);
        check("midrst_busy", busy, 0);
        check("midrst_step", step, 0);
        check("midrst_in_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        expect_idle("midrst_release");
        scan_word(8'h80, 1'b0, 0);

        for (int n = 0; n < 24; n++)
            scan_word(W'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        for (int n = 0; n < 4; n++)
            abort_at(W'($urandom), int'($urandom_range(0, H-1)));
        scan_word(8'h00, 1'b1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
